// File: rtl/bcd_counter_multi_if.sv
// Control and result bundle for bcd_counter_multi.
// The host side drives the controls and the counter side drives the results.
interface bcd_counter_multi_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc;
    logic         bad_load;

    modport master (
        output en, up, load, load_val,
        input  out, tc, bad_load
    );

    modport slave (
        input  en, up, load, load_val,
        output out, tc, bad_load
    );
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-decade up/down decimal counter with parallel load and a selectable output code.
// Digits are held internally as 8421 BCD. The output is re-encoded as 8421 BCD,
// 2421 (Aiken) or excess-3.
// Optional feature: define BCD_COUNTER_SATURATE_EN to make the counter saturate.
// With it defined, the counter holds at the terminal value instead of wrapping,
// and tc is a level that stays high while the counter is held there.
module bcd_counter_multi #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned CODE   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_counter_multi_if.slave     bus
);
    localparam int unsigned W = 4 * DIGITS;

    logic [3:0]   dig_q   [DIGITS];
    logic [3:0]   nxt_dig [DIGITS];
    logic [W-1:0] out_q;
    logic [W-1:0] nxt_out;
    logic         tc_q;
    logic         nxt_tc;
    logic         bad_q;
    logic         nxt_bad;
    logic         carry;
    logic [3:0]   ld;

    // Map one 8421 digit onto the selected output code.
    function automatic logic [3:0] encode(input logic [3:0] d);
        logic [3:0] r;
        if (CODE == 0) begin
            r = d;
        end else if (CODE == 2) begin
            r = 4'(d + 4'd3);
        end else begin
            // Aiken: the upper half of the range sits 6 above its 8421 value
            r = (d >= 4'd5) ? 4'(d + 4'd6) : d;
        end
        return r;
    endfunction

    // Next-state logic: load, then a counting step with a ripple carry/borrow, then hold.
    always_comb begin
        nxt_dig = dig_q;
        nxt_tc  = 1'b0;
        nxt_bad = bad_q;
        nxt_out = '0;
        carry   = 1'b0;
        ld      = '0;
        if (bus.load) begin
            nxt_bad = 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                ld = bus.load_val[4*i +: 4];
                if (ld > 4'd9) begin
                    nxt_dig[i] = 4'd0;
                    nxt_bad    = 1'b1;
                end else begin
                    nxt_dig[i] = ld;
                end
            end
        end else if (bus.en) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (bus.up) begin
                        if (dig_q[i] == 4'd9) begin
                            nxt_dig[i] = 4'd0;
                        end else begin
                            nxt_dig[i] = 4'(dig_q[i] + 4'd1);
                            carry      = 1'b0;
                        end
                    end else begin
                        if (dig_q[i] == 4'd0) begin
                            nxt_dig[i] = 4'd9;
                        end else begin
                            nxt_dig[i] = 4'(dig_q[i] - 4'd1);
                            carry      = 1'b0;
                        end
                    end
                end
            end
            // The carry leaving the top digit means the count was at its terminal value
            if (carry) begin
                nxt_tc = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
                nxt_dig = dig_q;
`endif
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nxt_out[4*i +: 4] = encode(nxt_dig[i]);
        end
    end

    // State and output registers; out is encoded from the next state, so it adds no latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig_q[i]          <= 4'd0;
                out_q[4*i +: 4]   <= encode(4'd0);
            end
            tc_q  <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            dig_q <= nxt_dig;
            out_q <= nxt_out;
            tc_q  <= nxt_tc;
            bad_q <= nxt_bad;
        end
    end

    assign bus.out      = out_q;
    assign bus.tc       = tc_q;
    assign bus.bad_load = bad_q;
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench for bcd_counter_multi with two digits.
// Three instances run side by side, one for each output code, and share the same stimulus.
// BCD_COUNTER_SATURATE_EN selects the saturating expectations.
module tb_bcd_counter_multi;
    localparam int unsigned DIGITS = 2;
    localparam int          MAXV   = 99;
    localparam logic [3:0]  AIKEN [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                           4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       up  = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    int val   = 0;
    bit tc_m  = 1'b0;
    bit bad_m = 1'b0;

    bcd_counter_multi_if #(.DIGITS(DIGITS)) bus0 ();
    bcd_counter_multi_if #(.DIGITS(DIGITS)) bus1 ();
    bcd_counter_multi_if #(.DIGITS(DIGITS)) bus2 ();

    assign bus0.en = en;  assign bus0.up = up;  assign bus0.load = load;  assign bus0.load_val = load_val;
    assign bus1.en = en;  assign bus1.up = up;  assign bus1.load = load;  assign bus1.load_val = load_val;
    assign bus2.en = en;  assign bus2.up = up;  assign bus2.load = load;  assign bus2.load_val = load_val;

    bcd_counter_multi #(.DIGITS(DIGITS), .CODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    bcd_counter_multi #(.DIGITS(DIGITS), .CODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bcd_counter_multi #(.DIGITS(DIGITS), .CODE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_out(input int code, input int v);
        logic [7:0] r;
        int d;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? (v % 10) : ((v / 10) % 10);
            case (code)
                0:       r[4*i +: 4] = 4'(d);
                1:       r[4*i +: 4] = AIKEN[d];
                default: r[4*i +: 4] = 4'(d + 3);
            endcase
        end
        return r;
    endfunction

    // Reference model: the count is a plain integer 0..99.
    task automatic model_step();
        int d;
        if (load) begin
            bad_m = 1'b0;
            val   = 0;
            for (int i = 1; i >= 0; i--) begin
                d = int'(load_val[4*i +: 4]);
                if (d > 9) begin
                    d     = 0;
                    bad_m = 1'b1;
                end
                val = val * 10 + d;
            end
            tc_m = 1'b0;
        end else if (en) begin
            tc_m = 1'b0;
            if (up) begin
                if (val == MAXV) begin
                    tc_m = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
                    val = 0;
`endif
                end else val = val + 1;
            end else begin
                if (val == 0) begin
                    tc_m = 1'b1;
`ifndef BCD_COUNTER_SATURATE_EN
                    val = MAXV;
`endif
                end else val = val - 1;
            end
        end else begin
            tc_m = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out8421"}, 32'(bus0.out), 32'(exp_out(0, val)));
        check({tag, ".out2421"}, 32'(bus1.out), 32'(exp_out(1, val)));
        check({tag, ".outxs3"},  32'(bus2.out), 32'(exp_out(2, val)));
        check({tag, ".tc"},      32'(bus0.tc),  32'(tc_m));
        check({tag, ".tc1"},     32'(bus1.tc),  32'(tc_m));
        check({tag, ".tc2"},     32'(bus2.tc),  32'(tc_m));
        check({tag, ".bad"},     32'(bus0.bad_load), 32'(bad_m));
        check({tag, ".bad2"},    32'(bus2.bad_load), 32'(bad_m));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        tick("load");
        load = 1'b0;
    endtask

    initial begin
        #12;
        check("rst.out8421", 32'(bus0.out), 32'h00);
        check("rst.out2421", 32'(bus1.out), 32'h00);
        check("rst.outxs3",  32'(bus2.out), 32'h33);
        check("rst.tc",      32'(bus0.tc),  32'h0);
        check("rst.bad",     32'(bus0.bad_load), 32'h0);
        rst = 1'b0;
        en  = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) tick("up5");
        check("up5.2421", 32'(bus1.out), 32'h0B);
        check("up5.xs3",  32'(bus2.out), 32'h38);

        do_load(8'h99);
        en = 1'b1; up = 1'b1;
        tick("wrap_up");
`ifndef BCD_COUNTER_SATURATE_EN
        check("wrap_up.out", 32'(bus1.out), 32'h00);
        check("wrap_up.tc",  32'(bus1.tc),  32'h1);
        tick("after_wrap");
        check("after_wrap.tc", 32'(bus1.tc), 32'h0);
`else
        check("sat_up.out", 32'(bus0.out), 32'h99);
        check("sat_up.tc",  32'(bus0.tc),  32'h1);
        do_load(8'h98);
        tick("sat1");
        check("sat1.tc", 32'(bus0.tc), 32'h0);
        tick("sat2");
        check("sat2.out", 32'(bus0.out), 32'h99);
        check("sat2.tc",  32'(bus0.tc),  32'h1);
        tick("sat3");
        check("sat3.tc",  32'(bus0.tc),  32'h1);
        up = 1'b0;
        tick("sat_rev");
        check("sat_rev.out", 32'(bus0.out), 32'h98);
        check("sat_rev.tc",  32'(bus0.tc),  32'h0);
`endif

        do_load(8'h10);
        up = 1'b0;
        tick("down10");
        check("down10.out", 32'(bus0.out), 32'h09);
        check("down10.tc",  32'(bus0.tc),  32'h0);
        do_load(8'h00);
        tick("down00");
`ifndef BCD_COUNTER_SATURATE_EN
        check("down00.out", 32'(bus0.out), 32'h99);
`else
        check("down00.out", 32'(bus0.out), 32'h00);
`endif
        check("down00.tc", 32'(bus0.tc), 32'h1);

        en = 1'b1;
        do_load(8'h3C);
        check("badld.out", 32'(bus0.out), 32'h30);
        check("badld.bad", 32'(bus0.bad_load), 32'h1);
        do_load(8'h25);
        check("goodld.bad", 32'(bus0.bad_load), 32'h0);
        do_load(8'h47);
        check("ld47.xs3", 32'(bus2.out), 32'h7A);

        // Asynchronous reset between edges while counting at 57
        do_load(8'h56);
        en = 1'b1; up = 1'b1;
        tick("at57");
        check("at57.out", 32'(bus0.out), 32'h57);
        #2 rst = 1'b1;
        #1;
        val = 0; tc_m = 1'b0; bad_m = 1'b0;
        check("arst.out8421", 32'(bus0.out), 32'h00);
        check("arst.outxs3",  32'(bus2.out), 32'h33);
        check("arst.tc",      32'(bus0.tc),  32'h0);
        #1 rst = 1'b0;
        tick("resume");
        check("resume.out", 32'(bus0.out), 32'h01);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 1) != 0);
            load = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 8'h99;
                1:       load_val = 8'h00;
                default: load_val = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            endcase
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
